// File: rtl/dff_skid_slice.sv
// Two-entry valid/ready register slice: main_q feeds out_data, skid_q absorbs the word that
// arrives while downstream stalls. Latency 1 cycle; in_ready drops only when both entries are full.
module dff_skid_slice #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             w_in_fire;
  logic             w_out_fire;

  // Handshake outputs decode the state flops only, so no input reaches an output combinationally.
  assign in_ready   = (r_state != FULL);
  assign out_valid  = (r_state != EMPTY);
  assign out_data   = r_main;
  assign count      = r_state;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_main_nxt  = in_data;
            w_state_nxt = BUSY;
          end
        end
        BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = in_data;
          end else if (w_in_fire) begin
            w_skid_nxt  = in_data;
            w_state_nxt = FULL;
          end else if (w_out_fire) begin
            w_state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (w_out_fire) begin
            w_main_nxt  = r_skid;
            w_state_nxt = BUSY;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

endmodule

// File: tb/tb_dff_skid_slice.sv
// Bench for dff_skid_slice (WIDTH=8): queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dff_skid_slice;

  logic       clk;
  logic       reset_n;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [1:0] count;

  int n_checks = 0;
  int n_errors = 0;

  dff_skid_slice #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of held words, capacity two.
  logic [7:0] q[$];
  bit         m_in_fire;
  bit         m_out_fire;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
    end else begin
      m_in_fire  = in_valid && (q.size() < 2);
      m_out_fire = out_ready && (q.size() > 0);
      if (flush) begin
        q.delete();
      end else begin
        if (m_out_fire) void'(q.pop_front());
        if (m_in_fire) q.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    chk("m_count", 32'(count), 32'(q.size()));
    chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("m_in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) chk("m_out_data", 32'(out_data), 32'(q[0]));
  end

  task automatic expect_out(input string tag, input logic v, input logic r,
                            input logic [1:0] c, input logic [7:0] d);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(r));
    chk({tag, "_count"}, 32'(count), 32'(c));
    if (v || !reset_n) chk({tag, "_out_data"}, 32'(out_data), 32'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    bit   ready_seen;
    int   sent;
    int   cyc;
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'hxx;
    out_ready = 1'b0;
    #1;
    expect_out("rst0", 1'b0, 1'b1, 2'd0, 8'h00);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Single pass-through with downstream stalled
    @(negedge clk); in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk); in_valid = 1'b0; in_data = 8'hxx;
    expect_out("single", 1'b1, 1'b1, 2'd1, 8'hA5);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    expect_out("single_drain", 1'b0, 1'b1, 2'd0, 8'h00);

    // Skid fill, third word blocked, then drain in order
    @(negedge clk); in_valid = 1'b1; in_data = 8'h11;
    @(negedge clk); in_data = 8'h22;
    @(negedge clk); expect_out("fill", 1'b1, 1'b0, 2'd2, 8'h11); in_data = 8'h33;
    @(negedge clk); expect_out("fill_hold", 1'b1, 1'b0, 2'd2, 8'h11); out_ready = 1'b1;
    @(negedge clk); expect_out("drain1", 1'b1, 1'b1, 2'd1, 8'h22);
    @(negedge clk); expect_out("drain2", 1'b1, 1'b1, 2'd1, 8'h33); in_valid = 1'b0; in_data = 8'hxx;
    @(negedge clk); expect_out("drain3", 1'b0, 1'b1, 2'd0, 8'h00);

    // Back-to-back stream at full rate
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i > 0) expect_out("stream", 1'b1, 1'b1, 2'd1, 8'(i - 1));
      if (i < 16) begin
        in_valid = 1'b1; in_data = 8'(i);
      end else begin
        in_valid = 1'b0; in_data = 8'hxx;
      end
    end
    @(negedge clk); expect_out("stream_end", 1'b0, 1'b1, 2'd0, 8'h00);

    // Random traffic with random backpressure; data is X whenever in_valid is low
    sent = 0; cyc = 0; ready_seen = in_ready;
    while (sent < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (in_valid && ready_seen) sent++;
      if (!in_valid || ready_seen) begin
        in_valid = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
        in_data  = in_valid ? 8'($urandom) : 8'hxx;
      end
      out_ready  = 1'($urandom_range(0, 1));
      ready_seen = in_ready;
    end
    chk("random_sent", 32'(sent), 32'd1000);
    in_valid = 1'b0; in_data = 8'hxx; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    expect_out("random_drain", 1'b0, 1'b1, 2'd0, 8'h00);

    // Flush while full with a competing input word
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_data = 8'h44;
    @(negedge clk); in_data = 8'h55;
    @(negedge clk); expect_out("pre_flush", 1'b1, 1'b0, 2'd2, 8'h44);
    flush = 1'b1; in_data = 8'h66;
    @(negedge clk); expect_out("flush", 1'b0, 1'b1, 2'd0, 8'h00);
    flush = 1'b0; in_data = 8'h77;
    @(negedge clk); expect_out("post_flush", 1'b1, 1'b1, 2'd1, 8'h77);
    in_valid = 1'b0; in_data = 8'hxx; out_ready = 1'b1;
    @(negedge clk); expect_out("post_flush_drain", 1'b0, 1'b1, 2'd0, 8'h00);

    // Asynchronous reset mid-run while holding two words
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_data = 8'hC3;
    @(negedge clk); in_data = 8'h3C;
    @(negedge clk); in_valid = 1'b0; in_data = 8'hxx;
    expect_out("pre_reset", 1'b1, 1'b0, 2'd2, 8'hC3);
    #2 reset_n = 1'b0;
    #1 expect_out("async_reset", 1'b0, 1'b1, 2'd0, 8'h00);
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_out("post_reset", 1'b0, 1'b1, 2'd0, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dff_skid_slice.md
Name: dff_skid_slice

Overview:
- Two-entry valid/ready register slice built from D flip-flops.
- Accepts words on an upstream handshake and re-presents them on a downstream handshake.
- All outputs are driven directly from flops. This breaks combinational paths on data, valid and ready.
- Instanced between pipeline stages wherever a bare Dff stage needs backpressure without throughput loss.

Parameters:
- WIDTH, 1, data word width in bits (WIDTH >= 1).

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge clk.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of stored words, active-high.
- in_valid  input  1  upstream word present.
- in_data  input  WIDTH  upstream word.
- in_ready  output  1  slice can accept a word this cycle.
- out_valid  output  1  word present on out_data.
- out_data  output  WIDTH  downstream word.
- out_ready  input  1  downstream accepts this cycle.
- count  output  2  number of words held (0..2).

Behaviour:
- Interface (already decided): one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset:
  - Asserting reset_n low immediately forces state EMPTY and clears main_q and skid_q to 0.
  - Outputs during reset: out_valid=0, in_ready=1, count=0, out_data=0.
  - Deassertion takes effect at the next posedge.
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - A transfer occurs only on a rising edge where the fire term is 1.
- Storage:
  - main_q drives out_data.
  - skid_q holds the overflow word.
- State machine:
  - States are EMPTY (count 0), BUSY (count 1) and FULL (count 2).
  - in_ready = (state != FULL), decoded from state flops only.
  - out_valid = (state != EMPTY).
  - count is the state encoding: EMPTY=0, BUSY=1, FULL=2.
- Transitions, evaluated in this order:
  - flush=1 -> EMPTY. Any in_fire that cycle is discarded and any out_fire is still counted as consumed. Data regs are held (don't-care), not cleared.
  - EMPTY & in_fire -> main_q<=in_data, BUSY.
  - BUSY & in_fire & out_fire -> main_q<=in_data, stay BUSY.
  - BUSY & in_fire & !out_fire -> skid_q<=in_data, FULL.
  - BUSY & !in_fire & out_fire -> EMPTY.
  - FULL & out_fire -> main_q<=skid_q, BUSY. in_fire is impossible in FULL because in_ready=0.
  - All other cases hold state and data.
- Latency and throughput:
  - A word accepted at edge N appears on out_data after edge N, with out_valid=1.
  - Sustained throughput is 1 word/cycle when out_ready is held 1.
- Ordering: strict FIFO. No word is lost, duplicated or reordered except by flush.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid do not change.
- Upstream contract: upstream must not drop in_valid or change in_data before in_fire. The slice does not check this.
- Reset mid-operation: stored words are discarded and no partial transfer completes.
- X-handling: in_data is never sampled unless in_fire. An X on in_data with in_valid=0 must not propagate.

Test Plan:
- Reset: hold reset_n=0 mid-run with count=2 -> immediately out_valid=0, in_ready=1, count=0, out_data=0. After release with in_valid=0 for 3 cycles, outputs stay unchanged.
- Single pass-through (WIDTH=8): in_valid=1, in_data=8'hA5 for one cycle with out_ready=0 -> next cycle out_valid=1, out_data=8'hA5, count=1, in_ready=1.
- Skid fill: with out_ready=0, send 8'h11 then 8'h22 -> count=2, in_ready=0, out_data=8'h11. A third word 8'h33 held on in_valid is not accepted. Then out_ready=1 -> out_data sequence 8'h11, 8'h22, 8'h33 on consecutive edges.
- Full throughput: stream 8'h00..8'h0F back-to-back with out_ready=1 -> 16 words out in order, one per cycle, 1-cycle latency, count stays 1, in_ready stays 1.
- Random backpressure: 1000 random words, in_valid and out_ready each 50% random -> scoreboard matches exactly in order. out_data/out_valid are stable whenever out_valid=1 and out_ready=0. count never exceeds 2.
- Flush: count=2 holding 8'h44,8'h55, assert flush=1 with in_valid=1, in_data=8'h66 -> next cycle count=0, out_valid=0, in_ready=1. 8'h66 is never output, and the next accepted word 8'h77 emerges first.
